// File: rtl/asteroid_draw_sequencer.sv
// Asteroid draw sequencer: walks the asteroid table once per frame and
// hands each active entry to the downstream sprite drawer, one at a time.
module asteroid_draw_sequencer #(
    parameter int NUM_AST = 8,
    parameter int TIMEOUT = 2048
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_AST)-1:0] wr_idx,
    input  logic [9:0]                 wr_x,
    input  logic [9:0]                 wr_y,
    input  logic [2:0]                 wr_sprite,
    input  logic                       wr_active,
    input  logic                       draw_done,
    output logic                       plot,
    output logic [9:0]                 x_pos,
    output logic [9:0]                 y_pos,
    output logic [2:0]                 sprite_sel,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_AST);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_AST - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Asteroid table storage
    logic [9:0]         tab_x_q   [NUM_AST];
    logic [9:0]         tab_x_d   [NUM_AST];
    logic [9:0]         tab_y_q   [NUM_AST];
    logic [9:0]         tab_y_d   [NUM_AST];
    logic [2:0]         tab_spr_q [NUM_AST];
    logic [2:0]         tab_spr_d [NUM_AST];
    logic [NUM_AST-1:0] tab_act_q;
    logic [NUM_AST-1:0] tab_act_d;

    // Sequencer state
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [2:0]    spr_q, spr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;

    // Helper decodes
    logic is_last;
    logic cur_active;
    logic wait_expired;
    logic wait_advance;

    assign is_last      = (idx_q == LAST_IDX);
    assign cur_active   = tab_act_q[idx_q];
    assign wait_expired = (cnt_q == CNT_LIMIT);
    assign wait_advance = draw_done || wait_expired;

    // Table write port: any state, all four fields at once
    always_comb begin
        tab_x_d   = tab_x_q;
        tab_y_d   = tab_y_q;
        tab_spr_d = tab_spr_q;
        tab_act_d = tab_act_q;
        if (wr_en) begin
            tab_x_d[wr_idx]   = wr_x;
            tab_y_d[wr_idx]   = wr_y;
            tab_spr_d[wr_idx] = wr_sprite;
            tab_act_d[wr_idx] = wr_active;
        end
    end

    // Active flags are cleared by reset; reset wins over a pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            tab_act_q <= '0;
        end else begin
            tab_act_q <= tab_act_d;
        end
    end

    // Coordinate/sprite fields need no reset, but reset still blocks writes
    always_ff @(posedge clk) begin
        if (!reset) begin
            tab_x_q   <= tab_x_d;
            tab_y_q   <= tab_y_d;
            tab_spr_q <= tab_spr_d;
        end
    end

    // Next-state logic for the table walk
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        spr_d   = spr_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    idx_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Reads the registered table, so a same-edge write is unseen
                if (cur_active) begin
                    x_d     = tab_x_q[idx_q];
                    y_d     = tab_y_q[idx_q];
                    spr_d   = tab_spr_q[idx_q];
                    state_d = S_ISSUE;
                end else if (is_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_advance) begin
                    if (!draw_done) begin
                        terr_d = 1'b1;
                    end
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_CHECK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            spr_q   <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            spr_q   <= spr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign plot        = (state_q == S_ISSUE);
    assign frame_done  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign sprite_sel  = spr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_asteroid_draw_sequencer.sv
// Bench for asteroid_draw_sequencer: directed scenarios plus random passes
// checked against a transaction-level timing model of a table walk.
module tb_asteroid_draw_sequencer;

    localparam int N  = 8;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [2:0] wr_sprite;
    logic       wr_active;
    logic       draw_done;
    logic       plot;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] sprite_sel;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference table and per-entry drawer delay (0 = drawer never answers)
    int mx [N];
    int my [N];
    int ms [N];
    bit ma [N];
    int dly [N];
    bit m_terr;

    asteroid_draw_sequencer #(
        .NUM_AST(N),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_sprite  (wr_sprite),
        .wr_active  (wr_active),
        .draw_done  (draw_done),
        .plot       (plot),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .sprite_sel (sprite_sel),
        .busy       (busy),
        .frame_done (frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int i, input int x, input int y,
                      input int s, input bit a);
        wr_en     = 1'b1;
        wr_idx    = 3'(i);
        wr_x      = 10'(x);
        wr_y      = 10'(y);
        wr_sprite = 3'(s);
        wr_active = a;
        @(negedge clk);
        wr_en = 1'b0;
        mx[i] = x;
        my[i] = y;
        ms[i] = s;
        ma[i] = a;
    endtask

    // One frame pass. Expected plot cycles and frame_done cycle are derived
    // from the walk rules: 1 cycle per inactive entry, plot one cycle after
    // its check, then a wait of the drawer delay capped at TO cycles.
    task automatic do_pass(input bit spur, input bit mw, input int mw_idx);
        int ep[$];
        int ei[$];
        int tc, p, w, t, k, dd_at, wr_t, done_t;
        bit te, seen;
        te = m_terr;
        tc = 1;
        for (int i = 0; i < N; i++) begin
            if (ma[i]) begin
                p = tc + 1;
                ep.push_back(p);
                ei.push_back(i);
                if (dly[i] == 0 || dly[i] > TO) begin
                    w  = TO - 1;
                    te = 1'b1;
                end else begin
                    w = dly[i] - 1;
                end
                tc = p + w + 2;
            end else begin
                tc++;
            end
        end
        done_t = tc;

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        t     = 1;
        k     = 0;
        dd_at = -1;
        wr_t  = -1;
        seen  = 1'b0;
        while (t <= done_t + 3 && !seen) begin
            draw_done   = spur;
            wr_en       = 1'b0;
            frame_start = ($urandom_range(0, 7) == 0);
            if (plot) begin
                if (k < ep.size()) begin
                    check("plot_t", t, ep[k]);
                    check("plot_x", x_pos, mx[ei[k]]);
                    check("plot_y", y_pos, my[ei[k]]);
                    check("plot_spr", sprite_sel, ms[ei[k]]);
                    if (dly[ei[k]] != 0) dd_at = t + dly[ei[k]];
                    if (mw && k == 0) wr_t = t + 1;
                end else begin
                    check("extra_plot", 1, 0);
                end
                k++;
            end else if (k > 0 && k <= ep.size()) begin
                check("hold_x", x_pos, mx[ei[k-1]]);
            end
            if (t == dd_at) draw_done = 1'b1;
            if (t == wr_t) begin
                wr_en       = 1'b1;
                wr_idx      = 3'(mw_idx);
                wr_x        = 10'd300;
                wr_y        = 10'(my[mw_idx]);
                wr_sprite   = 3'(ms[mw_idx]);
                wr_active   = ma[mw_idx];
                frame_start = 1'b1;
            end
            check("busy_pass", busy, 1);
            if (frame_done) begin
                seen = 1'b1;
                check("done_t", t, done_t);
                frame_start = 1'b0;
                draw_done   = 1'b0;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        frame_start = 1'b0;
        draw_done   = 1'b0;
        wr_en       = 1'b0;
        if (!seen) check("done_seen", 0, 1);
        check("plot_count", k, ep.size());
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("done_pulse", frame_done, 0);
        check("terr", timeout_err, te);
        m_terr = te;
        if (mw) mx[mw_idx] = 300;
    endtask

    initial begin
        int nw;
        bit seen_bad;
        reset       = 1'b1;
        frame_start = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_x        = '0;
        wr_y        = '0;
        wr_sprite   = '0;
        wr_active   = 1'b0;
        draw_done   = 1'b0;
        m_terr      = 1'b0;
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; ms[i] = 0; ma[i] = 1'b0; dly[i] = 5;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_plot", plot, 0);
        check("rst_done", frame_done, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_x", x_pos, 0);
        check("rst_y", y_pos, 0);
        check("rst_spr", sprite_sel, 0);
        reset = 1'b0;

        // Spurious draw_done while idle
        for (int i = 0; i < 3; i++) begin
            draw_done = 1'b1;
            @(negedge clk);
            check("spur_idle_busy", busy, 0);
            check("spur_idle_plot", plot, 0);
        end
        draw_done = 1'b0;

        // Empty table, draw_done held high through every check cycle
        do_pass(1'b1, 1'b0, 0);

        // Entries 0 and 3, drawer answers after 5 cycles
        wr(0, 10, 20, 1, 1'b1);
        wr(3, 200, 150, 4, 1'b1);
        do_pass(1'b0, 1'b0, 0);

        // Write entry 2 and re-request a frame while waiting on entry 2
        wr(0, 10, 20, 1, 1'b0);
        wr(3, 200, 150, 4, 1'b0);
        wr(2, 50, 60, 2, 1'b1);
        dly[2] = 6;
        do_pass(1'b0, 1'b1, 2);
        do_pass(1'b0, 1'b0, 0);

        // Drawer never answers entry 0: timeout, sticky error
        wr(2, 300, 60, 2, 1'b0);
        wr(0, 7, 9, 3, 1'b1);
        dly[0] = 0;
        do_pass(1'b0, 1'b0, 0);
        dly[0] = 3;
        do_pass(1'b0, 1'b0, 0);

        // Reset during WAIT, with a competing table write
        dly[0]      = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        seen_bad    = 1'b1;
        for (int i = 0; i < 10 && seen_bad; i++) begin
            if (plot) seen_bad = 1'b0;
            @(negedge clk);
        end
        check("rw_plot_seen", seen_bad, 0);
        @(negedge clk);
        reset     = 1'b1;
        wr_en     = 1'b1;
        wr_idx    = 3'd5;
        wr_active = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b0;
        check("rw_busy", busy, 0);
        check("rw_plot", plot, 0);
        check("rw_done", frame_done, 0);
        check("rw_terr", timeout_err, 0);
        seen_bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (frame_done || plot || busy) seen_bad = 1'b1;
        end
        check("rw_quiet", seen_bad, 0);
        for (int i = 0; i < N; i++) ma[i] = 1'b0;
        m_terr = 1'b0;
        do_pass(1'b0, 1'b0, 0);

        // Random passes
        for (int r = 0; r < 25; r++) begin
            nw = $urandom_range(0, 4);
            for (int j = 0; j < nw; j++) begin
                wr($urandom_range(0, N - 1), $urandom_range(0, 1023),
                   $urandom_range(0, 1023), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < N; i++) begin
                dly[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            end
            do_pass(1'b0, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
